// File: rtl/rvvi_host_frame_parser_if.sv
// rtl/rvvi_host_frame_parser_if.sv - MAC RX stream into the host frame parser
// tready is tied high at the MAC, so there is no back-pressure signal here.
interface rvvi_host_frame_parser_if;
   logic [31:0] RvviAxiRdata;
   logic [3:0]  RvviAxiRstrb;
   logic        RvviAxiRlast;
   logic        RvviAxiRvalid;

   modport master (
      output RvviAxiRdata,
      output RvviAxiRstrb,
      output RvviAxiRlast,
      output RvviAxiRvalid
   );

   modport slave (
      input RvviAxiRdata,
      input RvviAxiRstrb,
      input RvviAxiRlast,
      input RvviAxiRvalid
   );
endinterface

// File: rtl/rvvi_host_frame_parser.sv
// rtl/rvvi_host_frame_parser.sv - host-to-FPGA command frame filter and decoder
// Accepted commands strobe one cycle after tlast; rejected frames bump DropCount.
module rvvi_host_frame_parser #(
   parameter int          XLEN       = 64,
   parameter logic [47:0] DST_MAC    = 48'h4502_1111_6843,
   parameter logic [47:0] SRC_MAC    = 48'h8F54_0000_1654,
   parameter logic [15:0] ETH_TYPE   = 16'h005c,
   parameter logic [31:0] RATE_RESET = 32'd2
) (
   input  logic                         m_axi_aclk,
   input  logic                         m_axi_aresetn,
   rvvi_host_frame_parser_if.slave      rx,
   output logic                         TriggerValid,
   output logic                         SlowValid,
   output logic [31:0]                  SlowFill,
   output logic                         RateValid,
   output logic [31:0]                  RateValue,
   output logic                         AckValid,
   output logic [XLEN-1:0]              AckMinstr,
   output logic [31:0]                  AckDelay,
   output logic [15:0]                  DropCount
);

   typedef enum logic [1:0] {HDR, PAY, DONE, DISCARD} stateT;
   typedef enum logic [1:0] {CMD_TRIG, CMD_SLOW, CMD_RATE, CMD_ACK} cmdT;

   localparam logic [1:0] ACK_WORDS = (XLEN == 64) ? 2'd3 : 2'd2;

   stateT       state, stateNext;
   logic [1:0]  beatCnt, beatNext;
   logic [1:0]  payCnt, payNext;
   cmdT         cmdReg, cmdNext, cmdDec, acceptCmd;
   logic        cmdKnown;
   logic [31:0] shW4, shW5, shW6;
   logic [31:0] w4Next, w5Next, w6Next;
   logic [31:0] hdrWord;
   logic        hdrOk, keepOk, accept, reject;
   logic [1:0]  lastPay;
   logic [63:0] minstrNext;

   function automatic logic [1:0] needWords(input cmdT c);
      unique case (c)
         CMD_TRIG: needWords = 2'd0;
         CMD_SLOW: needWords = 2'd1;
         CMD_RATE: needWords = 2'd1;
         CMD_ACK:  needWords = ACK_WORDS;
      endcase
   endfunction

   always_comb begin
      cmdDec   = CMD_TRIG;
      cmdKnown = 1'b1;
      unique case (rx.RvviAxiRdata[31:16])
         16'h7274: cmdDec = CMD_TRIG;
         16'h6c73: cmdDec = CMD_SLOW;
         16'h6172: cmdDec = CMD_RATE;
         16'h6b61: cmdDec = CMD_ACK;
         default:  cmdKnown = 1'b0;
      endcase
   end

   always_comb begin
      hdrWord = DST_MAC[31:0];
      unique case (beatCnt)
         2'd0: hdrWord = DST_MAC[31:0];
         2'd1: hdrWord = {SRC_MAC[15:0], DST_MAC[47:32]};
         2'd2: hdrWord = SRC_MAC[47:16];
         2'd3: hdrWord = {16'h0000, ETH_TYPE};
      endcase
   end

   assign keepOk  = (rx.RvviAxiRstrb == 4'hF);
   assign hdrOk   = keepOk && ((beatCnt == 2'd3)
                     ? (rx.RvviAxiRdata[15:0] == ETH_TYPE && cmdKnown)
                     : (rx.RvviAxiRdata == hdrWord));
   assign lastPay = needWords(cmdReg) - 2'd1;

   always_comb begin
      stateNext = state;
      beatNext  = beatCnt;
      payNext   = payCnt;
      cmdNext   = cmdReg;
      acceptCmd = cmdReg;
      accept    = 1'b0;
      reject    = 1'b0;
      w4Next    = shW4;
      w5Next    = shW5;
      w6Next    = shW6;
      if (rx.RvviAxiRvalid) begin
         unique case (state)
            HDR: begin
               if (!hdrOk) begin
                  beatNext  = 2'd0;
                  reject    = rx.RvviAxiRlast;
                  stateNext = rx.RvviAxiRlast ? HDR : DISCARD;
               end else if (beatCnt != 2'd3) begin
                  beatNext = rx.RvviAxiRlast ? 2'd0 : beatCnt + 2'd1;
                  reject   = rx.RvviAxiRlast;
               end else begin
                  beatNext  = 2'd0;
                  payNext   = 2'd0;
                  cmdNext   = cmdDec;
                  acceptCmd = cmdDec;
                  if (needWords(cmdDec) == 2'd0) begin
                     accept    = rx.RvviAxiRlast;
                     stateNext = rx.RvviAxiRlast ? HDR : DONE;
                  end else begin
                     reject    = rx.RvviAxiRlast;
                     stateNext = rx.RvviAxiRlast ? HDR : PAY;
                  end
               end
            end
            PAY: begin
               if (!keepOk) begin
                  reject    = rx.RvviAxiRlast;
                  stateNext = rx.RvviAxiRlast ? HDR : DISCARD;
               end else begin
                  unique case (payCnt)
                     2'd0:    w4Next = rx.RvviAxiRdata;
                     2'd1:    w5Next = rx.RvviAxiRdata;
                     default: w6Next = rx.RvviAxiRdata;
                  endcase
                  if (payCnt == lastPay) begin
                     accept    = rx.RvviAxiRlast;
                     stateNext = rx.RvviAxiRlast ? HDR : DONE;
                  end else if (rx.RvviAxiRlast) begin
                     reject    = 1'b1;
                     stateNext = HDR;
                  end else begin
                     payNext = payCnt + 2'd1;
                  end
               end
            end
            DONE: begin
               if (rx.RvviAxiRlast) begin
                  accept    = 1'b1;
                  stateNext = HDR;
               end
            end
            DISCARD: begin
               if (rx.RvviAxiRlast) begin
                  reject    = 1'b1;
                  stateNext = HDR;
               end
            end
         endcase
      end
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state   <= HDR;
         beatCnt <= 2'd0;
         payCnt  <= 2'd0;
         cmdReg  <= CMD_TRIG;
         shW4    <= 32'd0;
         shW5    <= 32'd0;
         shW6    <= 32'd0;
      end else begin
         state   <= stateNext;
         beatCnt <= beatNext;
         payCnt  <= payNext;
         cmdReg  <= cmdNext;
         shW4    <= w4Next;
         shW5    <= w5Next;
         shW6    <= w6Next;
      end
   end

   // The final payload word may arrive on the tlast beat, so commit from the next-shadow values.
   assign minstrNext = {w6Next, w5Next};

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         TriggerValid <= 1'b0;
         SlowValid    <= 1'b0;
         RateValid    <= 1'b0;
         AckValid     <= 1'b0;
         SlowFill     <= 32'd0;
         RateValue    <= RATE_RESET;
         AckMinstr    <= '0;
         AckDelay     <= 32'd0;
         DropCount    <= 16'd0;
      end else begin
         TriggerValid <= accept && (acceptCmd == CMD_TRIG);
         SlowValid    <= accept && (acceptCmd == CMD_SLOW);
         RateValid    <= accept && (acceptCmd == CMD_RATE);
         AckValid     <= accept && (acceptCmd == CMD_ACK);
         if (accept && acceptCmd == CMD_SLOW) SlowFill <= w4Next;
         if (accept && acceptCmd == CMD_RATE) RateValue <= w4Next;
         if (accept && acceptCmd == CMD_ACK) begin
            AckDelay  <= w4Next;
            AckMinstr <= minstrNext[XLEN-1:0];
         end
         if (reject && DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_rvvi_host_frame_parser.sv
// tb/tb_rvvi_host_frame_parser.sv - directed bench for rvvi_host_frame_parser
// Beats are driven on the falling edge; outputs are sampled on the falling edge.
module tb_rvvi_host_frame_parser;
   localparam logic [31:0] W0 = 32'h1111_6843;
   localparam logic [31:0] W1 = 32'h1654_4502;
   localparam logic [31:0] W2 = 32'h8F54_0000;

   logic        clk;
   logic        rstN;
   logic        triggerValid, slowValid, rateValid, ackValid;
   logic [31:0] slowFill, rateValue, ackDelay;
   logic [63:0] ackMinstr;
   logic [15:0] dropCount;
   int          nAsserts, nFail;
   int          trigCnt, slowCnt, rateCnt, ackCnt;

   rvvi_host_frame_parser_if rx ();

   rvvi_host_frame_parser #(.XLEN(64)) dut (
      .m_axi_aclk    (clk),
      .m_axi_aresetn (rstN),
      .rx            (rx.slave),
      .TriggerValid  (triggerValid),
      .SlowValid     (slowValid),
      .SlowFill      (slowFill),
      .RateValid     (rateValid),
      .RateValue     (rateValue),
      .AckValid      (ackValid),
      .AckMinstr     (ackMinstr),
      .AckDelay      (ackDelay),
      .DropCount     (dropCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (triggerValid) trigCnt++;
      if (slowValid)    slowCnt++;
      if (rateValid)    rateCnt++;
      if (ackValid)     ackCnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      @(negedge clk);
      rx.RvviAxiRdata  = d;
      rx.RvviAxiRstrb  = k;
      rx.RvviAxiRlast  = l;
      rx.RvviAxiRvalid = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      rx.RvviAxiRdata  = 32'd0;
      rx.RvviAxiRstrb  = 4'h0;
      rx.RvviAxiRlast  = 1'b0;
      rx.RvviAxiRvalid = 1'b0;
   endtask

   task automatic frame5(input logic [31:0] a, b, c, d, e, input logic [3:0] k4);
      beat(a, 4'hF, 1'b0);
      beat(b, 4'hF, 1'b0);
      beat(c, 4'hF, 1'b0);
      beat(d, 4'hF, 1'b0);
      beat(e, k4, 1'b1);
   endtask

   task automatic checkReset(input string tag);
      check({tag, "_trig"}, {63'd0, triggerValid}, 64'd0);
      check({tag, "_slowv"}, {63'd0, slowValid}, 64'd0);
      check({tag, "_ratev"}, {63'd0, rateValid}, 64'd0);
      check({tag, "_ackv"}, {63'd0, ackValid}, 64'd0);
      check({tag, "_fill"}, {32'd0, slowFill}, 64'd0);
      check({tag, "_rate"}, {32'd0, rateValue}, 64'd2);
      check({tag, "_minstr"}, ackMinstr, 64'd0);
      check({tag, "_delay"}, {32'd0, ackDelay}, 64'd0);
      check({tag, "_drop"}, {48'd0, dropCount}, 64'd0);
   endtask

   initial begin
      nAsserts = 0; nFail = 0;
      trigCnt = 0; slowCnt = 0; rateCnt = 0; ackCnt = 0;
      rstN = 1'b0;
      rx.RvviAxiRdata = 32'd0; rx.RvviAxiRstrb = 4'h0;
      rx.RvviAxiRlast = 1'b0;  rx.RvviAxiRvalid = 1'b0;
      repeat (3) @(negedge clk);
      checkReset("reset");
      rstN = 1'b1;

      // Trigger frame: 4 header beats + 11 padding beats, tlast on beat 14
      beat(W0, 4'hF, 1'b0); beat(W1, 4'hF, 1'b0); beat(W2, 4'hF, 1'b0);
      beat(32'h7274_005c, 4'hF, 1'b0);
      for (int i = 0; i < 10; i++) beat(32'd0, 4'hF, 1'b0);
      beat(32'd0, 4'hF, 1'b1);
      idle();
      check("trig_pulse", {63'd0, triggerValid}, 64'd1);
      idle();
      check("trig_one_cycle", {63'd0, triggerValid}, 64'd0);
      check("trig_drop", {48'd0, dropCount}, 64'd0);

      // Rate frame, then slow frame with a 3-cycle gap inside the header
      frame5(W0, W1, W2, 32'h6172_005c, 32'd17, 4'hF);
      idle();
      check("rate_pulse", {63'd0, rateValid}, 64'd1);
      check("rate_value", {32'd0, rateValue}, 64'd17);
      beat(W0, 4'hF, 1'b0); beat(W1, 4'hF, 1'b0);
      idle(); idle(); idle();
      beat(W2, 4'hF, 1'b0); beat(32'h6c73_005c, 4'hF, 1'b0);
      beat(32'h0000_0400, 4'hF, 1'b1);
      idle();
      check("slow_pulse", {63'd0, slowValid}, 64'd1);
      check("slow_fill", {32'd0, slowFill}, 64'h400);
      check("rate_hold", {32'd0, rateValue}, 64'd17);
      idle();
      check("rate_count", trigCnt * 0 + rateCnt, 64'd1);
      check("slow_count", slowCnt, 64'd1);

      // Ack frame with 64-bit minstret
      beat(W0, 4'hF, 1'b0); beat(W1, 4'hF, 1'b0); beat(W2, 4'hF, 1'b0);
      beat(32'h6b61_005c, 4'hF, 1'b0); beat(32'd5, 4'hF, 1'b0);
      beat(32'hDEAD_BEEF, 4'hF, 1'b0); beat(32'h1, 4'hF, 1'b1);
      idle();
      check("ack_pulse", {63'd0, ackValid}, 64'd1);
      check("ack_minstr", ackMinstr, 64'h1_DEAD_BEEF);
      check("ack_delay", {32'd0, ackDelay}, 64'd5);

      // Four rejected frames of different kinds
      frame5(32'h1111_6844, W1, W2, 32'h6172_005c, 32'd99, 4'hF);
      frame5(W0, W1, W2, 32'h6172_0800, 32'd99, 4'hF);
      frame5(W0, W1, W2, 32'h1234_005c, 32'd99, 4'hF);
      frame5(W0, W1, W2, 32'h6172_005c, 32'd99, 4'h7);
      idle(); idle();
      check("bad_drop", {48'd0, dropCount}, 64'd4);
      check("bad_rate_hold", {32'd0, rateValue}, 64'd17);
      check("bad_strobes", trigCnt + slowCnt + rateCnt + ackCnt, 64'd4);

      // Short ack (tlast on W5) followed immediately by a trigger frame
      beat(W0, 4'hF, 1'b0); beat(W1, 4'hF, 1'b0); beat(W2, 4'hF, 1'b0);
      beat(32'h6b61_005c, 4'hF, 1'b0); beat(32'd7, 4'hF, 1'b0);
      beat(32'hCAFE_F00D, 4'hF, 1'b1);
      beat(W0, 4'hF, 1'b0);
      check("short_drop", {48'd0, dropCount}, 64'd5);
      check("short_minstr", ackMinstr, 64'h1_DEAD_BEEF);
      check("short_delay", {32'd0, ackDelay}, 64'd5);
      beat(W1, 4'hF, 1'b0); beat(W2, 4'hF, 1'b0);
      beat(32'h7274_005c, 4'hF, 1'b0); beat(32'd0, 4'hF, 1'b1);
      idle();
      check("b2b_trig", {63'd0, triggerValid}, 64'd1);
      check("b2b_ack_count", ackCnt, 64'd1);

      // Saturation
      idle();
      force dut.DropCount = 16'hFFFE;
      idle();
      release dut.DropCount;
      frame5(W0, W1, W2, 32'h1234_005c, 32'd0, 4'hF);
      idle();
      check("sat_first", {48'd0, dropCount}, 64'hFFFF);
      frame5(W0, W1, W2, 32'h1234_005c, 32'd0, 4'hF);
      frame5(W0, W1, W2, 32'h1234_005c, 32'd0, 4'hF);
      idle();
      check("sat_hold", {48'd0, dropCount}, 64'hFFFF);

      // Reset during W2 of a rate frame; the tail is parsed as a new frame
      beat(W0, 4'hF, 1'b0); beat(W1, 4'hF, 1'b0);
      beat(W2, 4'hF, 1'b0);
      rstN = 1'b0;
      idle(); idle();
      checkReset("midreset");
      rstN = 1'b1;
      beat(32'h6172_005c, 4'hF, 1'b0); beat(32'd17, 4'hF, 1'b1);
      idle();
      check("tail_rate", {32'd0, rateValue}, 64'd2);
      check("tail_ratev", {63'd0, rateValid}, 64'd0);
      check("tail_drop", {48'd0, dropCount}, 64'd1);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end
endmodule

// File: doc/rvvi_host_frame_parser.md
Name: rvvi_host_frame_parser

Overview:
- Receive-side stage directly downstream of the Ethernet MAC RX AXI-stream (32-bit) in the hardware tracer.
- Filters host-to-FPGA frames by MAC address and ethertype, decodes the 16-bit command code, and extracts payload words.
- Emits one-cycle command strobes to the tracer control logic: ILA trigger, slow-down request, packet-rate set, and instruction acknowledge.
- Counts rejected frames for debug.

Parameters:
- XLEN, 64, width of the acknowledged minstret; 32 or 64 only.
- DST_MAC, 48'h4502_1111_6843, required destination MAC, i.e. the FPGA's address.
- SRC_MAC, 48'h8F54_0000_1654, required source MAC, i.e. the host's address.
- ETH_TYPE, 16'h005c, required ethertype.
- RATE_RESET, 32'd2, reset value of RateValue.

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_aresetn  in  1  asynchronous active-low reset.
- RvviAxiRdata  in  32  RX stream data, byte 0 in [7:0].
- RvviAxiRstrb  in  4  RX tkeep.
- RvviAxiRlast  in  1  RX tlast.
- RvviAxiRvalid  in  1  RX tvalid. tready is tied 1 at the MAC, so every valid cycle is a beat.
- TriggerValid  out  1  trigger command strobe.
- SlowValid  out  1  slow-down command strobe.
- SlowFill  out  32  host FIFO fill amount carried by the last slow command.
- RateValid  out  1  rate command strobe.
- RateValue  out  32  inter-packet delay; sticky.
- AckValid  out  1  acknowledge strobe.
- AckMinstr  out  XLEN  acknowledged instret.
- AckDelay  out  32  host-requested inter-packet delay from the ack.
- DropCount  out  16  saturating count of rejected frames.

Behaviour:
- Frame word layout (beat index):
  - W0 = DST_MAC[31:0]
  - W1 = {SRC_MAC[15:0], DST_MAC[47:32]}
  - W2 = SRC_MAC[47:16]
  - W3 = {Cmd[15:0], ETH_TYPE}
  - W4.. = payload
- Commands and required payload words:
  - 16'h7274 trigger: 0 payload words.
  - 16'h6c73 slow: 1 word (fill).
  - 16'h6172 rate: 1 word (delay).
  - 16'h6b61 ack: W4 = delay, W5 = minstr[31:0]; when XLEN=64, W6 = minstr[63:32].
  - Any other Cmd is rejected.
- States:
  - HDR: 2-bit beat counter over W0-W3.
  - PAY: payload beat counter.
  - DONE: all required words captured; waiting for tlast.
  - DISCARD: frame rejected; waiting for tlast.
- Transitions:
  - HDR: W0-W2 mismatch, W3 ethertype mismatch, or unknown Cmd → DISCARD. Tlast on any beat before the required words are received → reject and return to HDR.
  - After W3: go to PAY if the command needs payload, else DONE.
  - PAY → DONE after the last required payload word.
  - DONE: extra beats (Ethernet padding to 60 bytes) are ignored; tkeep is not checked on them.
  - DONE or DISCARD with tlast → HDR.
- tkeep: every header and required payload beat must have tkeep = 4'hF; otherwise reject.
- Commit:
  - The strobe is asserted exactly one cycle after the tlast beat of an accepted frame, for one cycle only.
  - SlowFill, RateValue, AckMinstr and AckDelay update in that same cycle and hold until the next accepted command of their type.
  - Payload is captured into shadow registers; visible outputs never change on a rejected frame.
  - A frame that is a single beat with tlast is rejected.
- Rejection:
  - DropCount increments once per rejected frame, in the cycle after its tlast.
  - For a tlast-terminated short frame, the increment is in the cycle after that tlast.
  - DropCount saturates at 16'hFFFF.
- Back-to-back frames: a new W0 is accepted in the cycle immediately after the previous tlast. A strobe and the next frame's W0 may coincide.
- Reset (async assert, sync release), all outputs:
  - All strobes = 0.
  - SlowFill = 0, AckMinstr = 0, AckDelay = 0, DropCount = 0.
  - RateValue = RATE_RESET.
  - State = HDR, counters = 0.
- Reset mid-frame: the state machine returns to HDR. Remaining beats of the interrupted frame are parsed as a new frame, normally rejected and counted. Nothing else is required.
- Invalid cycles (Rvalid = 0) freeze the state machine; gaps inside a frame are legal.
- XLEN=32 ack: W6 is not required; AckMinstr = W5.

Test Plan:
- Trigger frame W0-W3 = 1111_6843, 1654_4502, 8F54_0000, 7274_005c, then 11 zero padding beats, tlast on beat 14 → TriggerValid high exactly one cycle after the tlast beat; DropCount = 0.
- Rate frame with W4 = 32'd17, followed by a slow frame with W4 = 32'h0000_0400, with valid deasserted for 3 cycles mid-header → RateValue = 17, RateValid pulses once; then SlowFill = 0x400, SlowValid pulses once; RateValue stays 17.
- Ack frame, XLEN=64, W4 = 5, W5 = 0xDEADBEEF, W6 = 0x1 → AckValid pulse; AckMinstr = 64'h1_DEAD_BEEF; AckDelay = 5.
- Wrong DST_MAC byte in W0 on a rate frame; ethertype 0x0800; unknown Cmd 0x1234; tkeep = 4'h7 on W4 → no strobes; RateValue unchanged; DropCount = 4.
- Ack frame with tlast on W5, XLEN=64 → rejected; DropCount +1; AckMinstr unchanged. A valid trigger frame starting the next cycle → accepted.
- Force DropCount to 16'hFFFE, then send 3 bad frames → DropCount = 16'hFFFF. Assert reset during W2 of a rate frame → all outputs at reset values, RateValue = 2.
